// File: rtl/alu_sequencer.sv
// Control stage for the 4-bit arithmetic unit: one instruction at a time over valid/ready,
// 4x4 register file, fixed-latency control window and writeback of the registered ALU result.
module alu_sequencer #(
   parameter int unsigned ARITH_LAT = 1,
   parameter int unsigned SHIFT_LAT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] instr,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic [1:0] rd_addr,
   output logic [3:0] rd_data,
   output logic       alu_add,
   output logic       alu_sub,
   output logic       alu_lshift,
   output logic       alu_rshift,
   output logic       alu_load,
   output logic [3:0] alu_in1,
   output logic [3:0] alu_in2,
   input  logic [3:0] alu_out,
   input  logic       alu_overflow,
   output logic [3:0] result,
   output logic       overflow,
   output logic       done,
   output logic       busy
);

   localparam int unsigned DW       = 4;
   localparam int unsigned RF_DEPTH = 4;
   localparam int unsigned CW       = 3;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_WB    = 2'd3;

   logic [1:0]    state, state_nxt;
   logic [CW-1:0] cnt;
   logic [DW-1:0] rf [RF_DEPTH];
   logic [1:0]    rd_q;
   logic [DW-1:0] opa_q, opb_q;
   logic [1:0]    op_c;
   logic          accept_c;

   assign op_c     = instr[7:6];
   assign accept_c = (state == S_IDLE) && instr_valid;
   assign rd_data  = rf[rd_addr];
   assign alu_in1  = opa_q;
   assign alu_in2  = opb_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: counter reaching zero ends the control window
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:          if (accept_c) state_nxt = S_ISSUE;
         S_ISSUE, S_WAIT: state_nxt = (cnt == CW'(1)) ? S_WB : S_WAIT;
         S_WB:            state_nxt = S_IDLE;
         default:         state_nxt = S_IDLE;
      endcase
   end

   // Datapath, register file and registered outputs; writeback overrides a colliding host write
   always_ff @(posedge clk) begin
      if (reset) begin
         rf          <= '{default: '0};
         rd_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         cnt         <= '0;
         alu_add     <= 1'b0;
         alu_sub     <= 1'b0;
         alu_lshift  <= 1'b0;
         alu_rshift  <= 1'b0;
         alu_load    <= 1'b0;
         result      <= '0;
         overflow    <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         instr_ready <= 1'b1;
      end else begin
         done        <= (state_nxt == S_WB);
         instr_ready <= (state_nxt == S_IDLE);
         busy        <= (state_nxt != S_IDLE);
         alu_load    <= 1'b0;
         if (wr_en) rf[wr_addr] <= wr_data;
         case (state)
            S_IDLE: begin
               if (accept_c) begin
                  rd_q       <= instr[5:4];
                  opa_q      <= rf[instr[3:2]];
                  opb_q      <= rf[instr[1:0]];
                  cnt        <= op_c[1] ? CW'(SHIFT_LAT) : CW'(ARITH_LAT);
                  alu_add    <= (op_c == 2'b00);
                  alu_sub    <= (op_c == 2'b01);
                  alu_lshift <= (op_c == 2'b10);
                  alu_rshift <= (op_c == 2'b11);
                  alu_load   <= op_c[1];
               end
            end
            S_ISSUE, S_WAIT: begin
               cnt <= cnt - CW'(1);
               if (state_nxt == S_WB) begin
                  alu_add    <= 1'b0;
                  alu_sub    <= 1'b0;
                  alu_lshift <= 1'b0;
                  alu_rshift <= 1'b0;
               end
            end
            S_WB: begin
               rf[rd_q] <= alu_out;
               result   <= alu_out;
               overflow <= alu_overflow;
            end
            default: ;
         endcase
      end
   end

endmodule
